// File: rtl/tocador_pkg.sv
// tocador_pkg: state encoding, note codes, half-period table and the
// 4-song x 16-step melody ROM shared by the player and its tone generator.
package tocador_pkg;
  typedef enum logic [1:0] {PARADO, TOCANDO, PAUSADO, FIM} estado_t;
  localparam int PASSO_W = 6;
  localparam logic [3:0] NOTA_PAUSA = 4'd0, NOTA_C4 = 4'd1, NOTA_CS4 = 4'd2, NOTA_D4 = 4'd3,
                         NOTA_DS4 = 4'd4, NOTA_E4 = 4'd5, NOTA_F4 = 4'd6, NOTA_FS4 = 4'd7,
                         NOTA_G4 = 4'd8, NOTA_GS4 = 4'd9, NOTA_A4 = 4'd10, NOTA_AS4 = 4'd11,
                         NOTA_B4 = 4'd12;
  function automatic logic eh_tom(input logic [3:0] n);
    return n != NOTA_PAUSA && n <= NOTA_B4;
  endfunction
  // half-period in 50 MHz cycles; rests and codes 13..15 return 0
  function automatic logic [16:0] meio_periodo(input logic [3:0] n);
    case (n)
      NOTA_C4:  return 17'd95556;
      NOTA_CS4: return 17'd90193;
      NOTA_D4:  return 17'd85131;
      NOTA_DS4: return 17'd80353;
      NOTA_E4:  return 17'd75843;
      NOTA_F4:  return 17'd71586;
      NOTA_FS4: return 17'd67568;
      NOTA_G4:  return 17'd63776;
      NOTA_GS4: return 17'd60196;
      NOTA_A4:  return 17'd56818;
      NOTA_AS4: return 17'd53629;
      NOTA_B4:  return 17'd50619;
      default:  return 17'd0;
    endcase
  endfunction
  // each step is {nota, dur}; step 0 is the leftmost pair
  function automatic logic [PASSO_W-1:0] rom_melodia(input logic [5:0] idx);
    logic [16*PASSO_W-1:0] m;
    case (idx[5:4])
      2'd0: m = {4'd10,2'd3, 4'd8,2'd1, 4'd5,2'd0, 4'd1,2'd2, 4'd0,2'd0, 4'd3,2'd1, 4'd12,2'd3, 4'd13,2'd0,
                 4'd7,2'd1, 4'd2,2'd0, 4'd10,2'd2, 4'd11,2'd1, 4'd6,2'd0, 4'd4,2'd3, 4'd9,2'd1, 4'd1,2'd3};
      2'd1: m = {4'd1,2'd0, 4'd3,2'd0, 4'd5,2'd0, 4'd6,2'd0, 4'd8,2'd0, 4'd10,2'd0, 4'd12,2'd0, 4'd1,2'd1,
                 4'd12,2'd1, 4'd10,2'd1, 4'd8,2'd1, 4'd6,2'd1, 4'd5,2'd1, 4'd3,2'd1, 4'd1,2'd1, 4'd0,2'd3};
      2'd2: m = {4'd5,2'd2, 4'd5,2'd0, 4'd6,2'd1, 4'd8,2'd3, 4'd8,2'd0, 4'd6,2'd0, 4'd5,2'd1, 4'd3,2'd1,
                 4'd1,2'd2, 4'd1,2'd0, 4'd3,2'd0, 4'd5,2'd1, 4'd5,2'd2, 4'd3,2'd0, 4'd3,2'd3, 4'd15,2'd1};
      default: m = {4'd12,2'd1, 4'd11,2'd1, 4'd10,2'd1, 4'd9,2'd1, 4'd8,2'd1, 4'd7,2'd1, 4'd6,2'd1, 4'd5,2'd1,
                    4'd4,2'd1, 4'd3,2'd1, 4'd2,2'd1, 4'd1,2'd1, 4'd0,2'd1, 4'd14,2'd1, 4'd10,2'd3, 4'd10,2'd3};
    endcase
    return m[(4'd15 - idx[3:0]) * PASSO_W +: PASSO_W];
  endfunction
endpackage

// File: rtl/gerador_tom.sv
// gerador_tom: half-period counter and buzzer flip-flop; clear wins over enable.
module gerador_tom (
  input  logic        clk_placa,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [16:0] i_meio,
  output logic        o_buz
);
  logic [16:0] r_cnt;
  logic        r_buz;
  logic        w_vira;
  assign w_vira = r_cnt == i_meio - 17'd1;
  always_ff @(posedge clk_placa)
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
      r_buz <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_vira ? '0 : r_cnt + 17'd1;
      r_buz <= w_vira ? ~r_buz : r_buz;
    end
  assign o_buz = r_buz;
endmodule

// File: rtl/tocador_musica.sv
// tocador_musica: 4-song buzzer player with stop/play/pause control.
// Define TOCADOR_LOOP_EN to repeat the song forever instead of stopping in FIM.
module tocador_musica import tocador_pkg::*; #(
  parameter int UNIT_CYC  = 12_500_000,
  parameter int TOM_SHIFT = 0
) (
  input  logic       clk_placa,
  input  logic       rst_n,
  input  logic       stop,
  input  logic       play,
  input  logic [1:0] sel,
  output logic       buzzer,
  output logic [3:0] nota_atual,
  output logic [3:0] passo,
  output logic       fim
);
  estado_t            r_estado;
  logic               r_stop, r_play, r_fim;
  logic [1:0]         r_sel, r_musica, r_cnt_uni;
  logic [3:0]         r_passo;
  logic [23:0]        r_cnt_dur;
  logic [PASSO_W-1:0] w_rom;
  logic [3:0]         w_nota;
  logic [1:0]         w_dur;
  logic [16:0]        w_meio;
  logic               w_tom, w_tocando, w_fim_unid, w_fim_passo, w_buz;
  assign w_rom       = rom_melodia({r_musica, r_passo});
  assign w_nota      = w_rom[5:2];
  assign w_dur       = w_rom[1:0];
  assign w_tom       = eh_tom(w_nota);
  assign w_meio      = meio_periodo(w_nota) >> TOM_SHIFT;
  assign w_tocando   = r_estado == TOCANDO;
  // duration is counted as units x cycles-per-unit so 24 bits cover a 4-unit step
  assign w_fim_unid  = r_cnt_dur == 24'(UNIT_CYC - 1);
  assign w_fim_passo = w_fim_unid && r_cnt_uni == w_dur;
  always_ff @(posedge clk_placa)
    if (!rst_n) begin
      r_stop    <= 1'b1;
      r_play    <= 1'b0;
      r_sel     <= '0;
      r_musica  <= '0;
      r_estado  <= PARADO;
      r_passo   <= '0;
      r_cnt_dur <= '0;
      r_cnt_uni <= '0;
      r_fim     <= 1'b0;
    end else begin
      r_stop <= stop;
      r_play <= play;
      r_sel  <= sel;
      if (r_estado == PARADO) r_musica <= r_sel;
      if (r_stop) begin
        r_estado  <= PARADO;
        r_passo   <= '0;
        r_cnt_dur <= '0;
        r_cnt_uni <= '0;
        r_fim     <= 1'b0;
      end else case (r_estado)
        PARADO, PAUSADO: if (r_play) r_estado <= TOCANDO;
        TOCANDO: begin
          if (!r_play) r_estado <= PAUSADO;
          if (!w_fim_passo) begin
            r_cnt_dur <= w_fim_unid ? '0 : r_cnt_dur + 24'd1;
            r_cnt_uni <= w_fim_unid ? r_cnt_uni + 2'd1 : r_cnt_uni;
          end else begin
            r_cnt_dur <= '0;
            r_cnt_uni <= '0;
`ifdef TOCADOR_LOOP_EN
            r_passo <= r_passo + 4'd1;
`else
            if (r_passo == 4'd15) begin
              r_estado <= FIM;
              r_fim    <= 1'b1;
            end else r_passo <= r_passo + 4'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  gerador_tom u_tom (
    .clk_placa (clk_placa),
    .rst_n     (rst_n),
    .i_en      (w_tocando && w_tom),
    .i_clr     (r_stop || (w_tocando && w_fim_passo)),
    .i_meio    (w_meio),
    .o_buz     (w_buz)
  );
  assign buzzer     = w_buz && w_tocando && w_tom;
  assign nota_atual = (w_tocando && w_tom) ? w_nota : 4'd0;
  assign passo      = r_passo;
  assign fim        = r_fim;
endmodule
